// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply-accumulate block:
// accumulate opcode encoding, FSM state type and opcode decode helpers.
package hilo_pkg;

  localparam logic [1:0] OP_MADD  = 2'd0;
  localparam logic [1:0] OP_MADDU = 2'd1;
  localparam logic [1:0] OP_MSUB  = 2'd2;
  localparam logic [1:0] OP_MSUBU = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  // Even opcodes treat the operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Opcodes 2 and 3 subtract the product from {HI,LO}.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/hilo_mul.sv
// Registered DATA_W x DATA_W -> 2*DATA_W multiplier, signed or unsigned,
// loading its output register only when en is high.
module hilo_mul
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] prod
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extending both operands to full width first makes one unsigned multiply,
  // truncated to 2*DATA_W bits, correct for both signed and unsigned inputs.
  assign a_ext = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign b_ext = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};

  // Product register: cleared by reset, loaded while enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      prod <= '0;
    end else if (en) begin
      prod <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with direct writes and a two-stage multiply-accumulate
// (MADD/MADDU/MSUB/MSUBU). FSM: IDLE -> MUL (product registered) -> ACC
// ({HI,LO} updated) -> IDLE.
// Optional build macro HILO_BYPASS_EN: hi_o/lo_o forward accepted direct-write
// data in the same cycle instead of waiting for the register update.
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              acc_valid,
  input  logic [1:0]        acc_op,
  input  logic [DATA_W-1:0] acc_a,
  input  logic [DATA_W-1:0] acc_b,
  output logic              acc_ready,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  state_t              state;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic [1:0]          op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] acc_next;

  assign acc_ready = (state == S_IDLE) && !we_hi && !we_lo;
  assign busy      = (state != S_IDLE);

  assign acc_next = op_is_sub(op_r) ? ({hi_r, lo_r} - prod)
                                    : ({hi_r, lo_r} + prod);

  hilo_mul #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .en        (state == S_MUL),
    .is_signed (op_is_signed(op_r)),
    .a         (a_r),
    .b         (b_r),
    .prod      (prod)
  );

  // Control FSM with HI/LO, captured operands and the done/wr_drop pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand/opcode capture registers are reset too, so a
      // request aborted by reset leaves no stale operands behind.
      state   <= S_IDLE;
      hi_r    <= '0;
      lo_r    <= '0;
      op_r    <= OP_MADD;
      a_r     <= '0;
      b_r     <= '0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (we_hi) hi_r <= hi_i;
          if (we_lo) lo_r <= lo_i;
          if (acc_valid && acc_ready) begin
            op_r  <= acc_op;
            a_r   <= acc_a;
            b_r   <= acc_b;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          wr_drop <= we_hi || we_lo;
          state   <= S_ACC;
        end
        S_ACC: begin
          wr_drop      <= we_hi || we_lo;
          {hi_r, lo_r} <= acc_next;
          done         <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  logic wr_ok;
  assign wr_ok = (state == S_IDLE) && !rst;
  assign hi_o  = (we_hi && wr_ok) ? hi_i : hi_r;
  assign lo_o  = (we_lo && wr_ok) ? lo_i : lo_r;
`else
  assign hi_o = hi_r;
  assign lo_o = lo_r;
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc (DATA_W=32): a cycle-by-cycle vector table
// plus hand-written sequences for reset mid-operation and write bypass.
module tb_hilo_acc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         we_hi, we_lo;
  logic [W-1:0] hi_i, lo_i;
  logic         acc_valid;
  logic [1:0]   acc_op;
  logic [W-1:0] acc_a, acc_b;
  logic         acc_ready, busy, done, wr_drop;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  hilo_acc #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .we_hi     (we_hi),
    .we_lo     (we_lo),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .acc_valid (acc_valid),
    .acc_op    (acc_op),
    .acc_a     (acc_a),
    .acc_b     (acc_b),
    .acc_ready (acc_ready),
    .busy      (busy),
    .done      (done),
    .wr_drop   (wr_drop),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         we_hi;
    logic         we_lo;
    logic [W-1:0] hi_i;
    logic [W-1:0] lo_i;
    logic         acc_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_busy;
    logic         e_done;
    logic         e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
    acc_valid = 1'b0; acc_op = 2'd0; acc_a = '0; acc_b = '0;
  endtask

  task automatic add(input logic r, input logic wh, input logic wl,
                     input logic [W-1:0] hv, input logic [W-1:0] lv,
                     input logic av, input logic [1:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el,
                     input logic eb, input logic ed, input logic edr);
    vec_t v;
    v.rst = r; v.we_hi = wh; v.we_lo = wl; v.hi_i = hv; v.lo_i = lv;
    v.acc_valid = av; v.op = op; v.a = a; v.b = b;
    v.e_hi = eh; v.e_lo = el; v.e_busy = eb; v.e_done = ed; v.e_drop = edr;
    vecs.push_back(v);
  endtask

  // Drive one row for one cycle, then remove the stimulus and check the
  // registered outputs produced by that edge.
  task automatic apply(input int idx, input vec_t v);
    rst = v.rst; we_hi = v.we_hi; we_lo = v.we_lo; hi_i = v.hi_i; lo_i = v.lo_i;
    acc_valid = v.acc_valid; acc_op = v.op; acc_a = v.a; acc_b = v.b;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check($sformatf("row%0d hi_o", idx), 64'(hi_o), 64'(v.e_hi));
    check($sformatf("row%0d lo_o", idx), 64'(lo_o), 64'(v.e_lo));
    check($sformatf("row%0d busy", idx), 64'(busy), 64'(v.e_busy));
    check($sformatf("row%0d acc_ready", idx), 64'(acc_ready), 64'(!v.e_busy));
    check($sformatf("row%0d done", idx), 64'(done), 64'(v.e_done));
    check($sformatf("row%0d wr_drop", idx), 64'(wr_drop), 64'(v.e_drop));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //   rst wh wl hi_i          lo_i          av op a             b             e_hi          e_lo          bsy dn drp
    // Reset beats simultaneous writes and a request.
    add(1, 1, 1, 32'h1,        32'h2,        1, 0, 32'h3,        32'h4,        32'h0,        32'h0,        0, 0, 0);
    // Split writes.
    add(0, 1, 0, 32'h5,        32'h0,        0, 0, 32'h0,        32'h0,        32'h5,        32'h0,        0, 0, 0);
    add(0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        32'h5,        32'hDEADBEEF, 0, 0, 0);
    add(0, 1, 1, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    // MADD: 0 + (-1 * 2) = -2.
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'hFFFFFFFF, 32'h2,        32'h0,        32'h0,        1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0);
    // MADDU wrap: all-ones + 1*1 = 0.
    add(0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h1,        32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0);
    // Conflict: a direct write during MUL is dropped, the ACC result lands.
    add(0, 1, 1, 32'h10,       32'h0,        0, 0, 32'h0,        32'h0,        32'h10,       32'h0,        0, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h3,        32'h4,        32'h10,       32'h0,        1, 0, 0);
    add(0, 1, 0, 32'hAAAA,     32'h0,        0, 0, 32'h0,        32'h0,        32'h10,       32'h0,        1, 0, 1);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h10,       32'hC,        0, 1, 0);
    // MSUB signed: 0x10_0000000C - 2*3.
    add(0, 0, 0, 32'h0,        32'h0,        1, 2, 32'h2,        32'h3,        32'h10,       32'hC,        1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h10,       32'hC,        1, 0, 0);
    // A request presented during ACC is ignored and not queued.
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h64,       32'h64,       32'h10,       32'h6,        0, 1, 0);
    // Back-to-back: accepted in the done cycle. MSUBU of (2^32-1)^2.
    add(0, 0, 0, 32'h0,        32'h0,        1, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10,       32'h6,        1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h10,       32'h6,        1, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h12,       32'h5,        0, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h12,       32'h5,        0, 0, 0);
    // A direct write wins over a same-cycle request.
    add(0, 0, 1, 32'h0,        32'h77,       1, 0, 32'h5,        32'h5,        32'h12,       32'h77,       0, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        32'h12,       32'h77,       0, 0, 0);

    // Hold reset across a couple of edges before the table starts.
    step();
    step();
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Reset asserted during ACC aborts with no partial update and no done.
    we_hi = 1'b1; we_lo = 1'b1; hi_i = 32'h1; lo_i = 32'h1;
    step();
    idle_inputs();
    acc_valid = 1'b1; acc_op = 2'd0; acc_a = 32'h2; acc_b = 32'h2;
    step();
    idle_inputs();
    check("midop in MUL busy", 64'(busy), 64'd1);
    step();
    check("midop in ACC busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midop hi_o", 64'(hi_o), 64'h0);
    check("midop lo_o", 64'(lo_o), 64'h0);
    check("midop busy", 64'(busy), 64'd0);
    check("midop done", 64'(done), 64'd0);
    step();
    check("midop done later", 64'(done), 64'd0);
    check("midop lo_o later", 64'(lo_o), 64'h0);

    // Direct write of 0x7 in IDLE: same-cycle view depends on the bypass build.
    we_hi = 1'b1; hi_i = 32'h7;
    #1;
`ifdef HILO_BYPASS_EN
    check("bypass same cycle hi_o", 64'(hi_o), 64'h7);
`else
    check("no bypass same cycle hi_o", 64'(hi_o), 64'h0);
`endif
    check("bypass lo_o untouched", 64'(lo_o), 64'h0);
    step();
    idle_inputs();
    #1;
    check("write registered hi_o", 64'(hi_o), 64'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each of HI and LO.
REQ-002 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports we_hi / we_lo  in  1 each  independent direct-write enables for HI and LO.
REQ-005 SHALL have ports hi_i / lo_i  in  DATA_W each  direct-write data.
REQ-006 SHALL have port acc_valid  in  1  accumulate request.
REQ-007 SHALL have port acc_op  in  2  operation: 0 MADD signed, 1 MADDU unsigned, 2 MSUB signed, 3 MSUBU unsigned.
REQ-008 SHALL have ports acc_a / acc_b  in  DATA_W each  multiplicand operands.
REQ-009 SHALL have port acc_ready  out  1  high when a request can be accepted.
REQ-010 SHALL have port busy  out  1  high while an accumulate is in flight.
REQ-011 SHALL have port done  out  1  one-cycle pulse when the accumulate result is written.
REQ-012 SHALL have port wr_drop  out  1  one-cycle pulse when a direct write is discarded.
REQ-013 SHALL have ports hi_o / lo_o  out  DATA_W each  current HI/LO values.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, MUL, ACC.
REQ-015 acc_ready SHALL be high only in IDLE with we_hi and we_lo both low; a request is accepted when acc_valid and acc_ready are both high.
REQ-016 In IDLE, direct writes SHALL update only the enabled half(s) at the next edge; a direct write takes priority over acc_valid in the same cycle, and the request is not accepted.
REQ-017 On acceptance, the FSM SHALL go IDLE->MUL and latch acc_op.
REQ-018 In MUL, the FSM SHALL register the 2*DATA_W product of acc_a and acc_b as captured at acceptance: sign-extended for ops 0/2, zero-extended for ops 1/3. The FSM then goes MUL->ACC.
REQ-019 In ACC, the FSM SHALL write {HI,LO} = {HI,LO} + product (ops 0/1) or - product (ops 2/3), modulo 2^(2*DATA_W), and return to IDLE.
REQ-020 Latency SHALL be: accept edge, +1 MUL, +1 ACC; the result is visible on hi_o/lo_o from the edge ending ACC. done SHALL be high for exactly the cycle after that edge.
REQ-021 busy SHALL be high in MUL and ACC, and low in IDLE.
REQ-022 Direct writes asserted in MUL or ACC SHALL be ignored, and wr_drop SHALL pulse one cycle later.
REQ-023 acc_valid outside IDLE SHALL be ignored; no queueing.
REQ-024 Back-to-back accumulates SHALL be possible: a new request may be accepted in the cycle done is high.

Reset
REQ-025 rst SHALL force the state to IDLE, HI=0, LO=0, product register=0, done=0 and wr_drop=0.
REQ-026 rst asserted in MUL or ACC SHALL abort the operation with no partial HI/LO update.
REQ-027 rst SHALL take priority over all writes and requests in the same cycle.

Configuration
REQ-028 Macro HILO_BYPASS_EN defined: hi_o/lo_o SHALL combinationally forward hi_i/lo_i for each half whose write enable is high and will be accepted (IDLE, not reset); otherwise they show the registered values.
REQ-029 HILO_BYPASS_EN undefined: hi_o/lo_o SHALL be the registered values only.

Structure
REQ-030 A shared package hilo_pkg SHALL hold the acc_op encoding constants and the FSM state type.
REQ-031 The product stage SHALL be a sub-module hilo_mul: registered signed/unsigned DATA_W x DATA_W -> 2*DATA_W multiplier with an enable.

Verification (DATA_W=32)
REQ-032 Reset: assert rst, then write hi_i=0x1, lo_i=0x2 with rst high -> hi_o=lo_o=0 and done=0.
REQ-033 Split write: we_lo=1, lo_i=0xDEADBEEF with HI=0x5 -> LO=0xDEADBEEF and HI stays 0x5.
REQ-034 MADD: HI:LO=0, a=0xFFFFFFFF (-1), b=2, op 0 -> after 2 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses once.
REQ-035 MADDU wrap: HI:LO=0xFFFFFFFF_FFFFFFFF, a=1, b=1, op 1 -> HI=0, LO=0.
REQ-036 Conflict: we_hi=1 during MUL -> HI unchanged by the write, wr_drop pulses, and the ACC result is applied.
REQ-037 Reset mid-op: rst asserted in ACC -> HI=LO=0, busy=0, no done; with HILO_BYPASS_EN, a write of 0x7 in IDLE shows hi_o=0x7 in the same cycle.
